// File: rtl/unidade_controle_jogo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unidade_controle_jogo                                                      |
// | Moore control FSM for the memory game: rounds, moves, per-move timeout.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module unidade_controle_jogo #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TIMER_W-1:0] c_timer_max = TIMER_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicio_rodada  = 4'h2,
    espera_jogada  = 4'h3,
    registra       = 4'h4,
    comparacao     = 4'h5,
    proxima_jogada = 4'h6,
    proxima_rodada = 4'h7,
    fim_acertou    = 4'hA,
    fim_timeout    = 4'hD,
    fim_errou      = 4'hE
  } estado_t;

  estado_t              r_estado;
  estado_t              w_estado_prox;
  logic [TIMER_W-1:0]   r_timer;

  always_comb begin
    w_estado_prox = inicial;
    case (r_estado)
      inicial:        w_estado_prox = jogar ? preparacao : inicial;
      preparacao:     w_estado_prox = inicio_rodada;
      inicio_rodada:  w_estado_prox = espera_jogada;
      // A button press in the same cycle as the deadline still counts.
      espera_jogada: begin
        if (jogada)
          w_estado_prox = registra;
        else if (r_timer == c_timer_max)
          w_estado_prox = fim_timeout;
        else
          w_estado_prox = espera_jogada;
      end
      registra:       w_estado_prox = comparacao;
      comparacao: begin
        if (!igual)
          w_estado_prox = fim_errou;
        else if (!enderecoIgualLimite)
          w_estado_prox = proxima_jogada;
        else if (fimL)
          w_estado_prox = fim_acertou;
        else
          w_estado_prox = proxima_rodada;
      end
      proxima_jogada: w_estado_prox = espera_jogada;
      proxima_rodada: w_estado_prox = inicio_rodada;
      fim_acertou:    w_estado_prox = jogar ? preparacao : fim_acertou;
      fim_timeout:    w_estado_prox = jogar ? preparacao : fim_timeout;
      fim_errou:      w_estado_prox = jogar ? preparacao : fim_errou;
      default:        w_estado_prox = inicial;
    endcase
  end

  // Outputs are registered from the next state, so they always equal a
  // decode of the state register and carry no combinational glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= inicial;
      r_timer    <= '0;
      zeraE      <= 1'b0;
      contaE     <= 1'b0;
      zeraL      <= 1'b0;
      contaL     <= 1'b0;
      zeraR      <= 1'b0;
      registraR  <= 1'b0;
      pronto     <= 1'b0;
      ganhou     <= 1'b0;
      perdeu     <= 1'b0;
      db_timeout <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;
      if (r_estado == espera_jogada && w_estado_prox == espera_jogada)
        r_timer <= (r_timer == c_timer_max) ? r_timer : r_timer + 1'b1;
      else
        r_timer <= '0;
      zeraE      <= (w_estado_prox == preparacao) || (w_estado_prox == inicio_rodada);
      contaE     <= (w_estado_prox == proxima_jogada);
      zeraL      <= (w_estado_prox == preparacao);
      contaL     <= (w_estado_prox == proxima_rodada);
      zeraR      <= (w_estado_prox == preparacao);
      registraR  <= (w_estado_prox == registra);
      pronto     <= (w_estado_prox == fim_acertou) || (w_estado_prox == fim_timeout) ||
                    (w_estado_prox == fim_errou);
      ganhou     <= (w_estado_prox == fim_acertou);
      perdeu     <= (w_estado_prox == fim_timeout) || (w_estado_prox == fim_errou);
      db_timeout <= (w_estado_prox == fim_timeout);
    end
  end

  assign db_estado = r_estado;

endmodule
`default_nettype wire
